// File: rtl/comparator.sv
// Registered magnitude comparator: an MSB-first mux cascade decides a>b / a==b,
// and the same decision steers max_out/min_out. Results land one edge after sampling.
module comparator #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             signed_mode,
    output logic             greater,
    output logic             lesser,
    output logic             equal,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic             out_valid
);

    logic eq_run;
    logic gt_run;
    logic bit_eq;
    logic bit_gt;
    logic lt_dec;

    // Each stage keeps the verdict from the higher bits unless they were all equal.
    // In signed mode the sign bit is inverted, so MSB=0 is the larger operand.
    always_comb begin
        eq_run = 1'b1;
        gt_run = 1'b0;
        bit_eq = 1'b0;
        bit_gt = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            bit_eq = (a[i] == b[i]);
            if (i == WIDTH - 1 && signed_mode) begin
                bit_gt = b[i] & ~a[i];
            end else begin
                bit_gt = a[i] & ~b[i];
            end
            gt_run = eq_run ? bit_gt : gt_run;
            eq_run = eq_run & bit_eq;
        end
        lt_dec = ~gt_run & ~eq_run;
    end

    // All-zero flags after reset mean "no result yet"; results hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            greater   <= 1'b0;
            lesser    <= 1'b0;
            equal     <= 1'b0;
            max_out   <= '0;
            min_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                greater <= gt_run;
                lesser  <= lt_dec;
                equal   <= eq_run;
                max_out <= gt_run ? a : b;
                min_out <= gt_run ? b : a;
            end
        end
    end

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed cases at widths 1/4/8/16 plus a
// randomized 16-bit stream checked against an integer-arithmetic reference model.
module tb_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [0:0]  a1 = '0, b1 = '0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic v1 = 0, v4 = 0, v8 = 0, v16 = 0;
    logic s1 = 0, s4 = 0, s8 = 0, s16 = 0;

    logic g1, l1, e1, ov1;
    logic g4, l4, e4, ov4;
    logic g8, l8, e8, ov8;
    logic g16, l16, e16, ov16;
    logic [0:0]  mx1, mn1;
    logic [3:0]  mx4, mn4;
    logic [7:0]  mx8, mn8;
    logic [15:0] mx16, mn16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1), .signed_mode(s1),
        .greater(g1), .lesser(l1), .equal(e1), .max_out(mx1), .min_out(mn1), .out_valid(ov1));
    comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4), .signed_mode(s4),
        .greater(g4), .lesser(l4), .equal(e4), .max_out(mx4), .min_out(mn4), .out_valid(ov4));
    comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8), .signed_mode(s8),
        .greater(g8), .lesser(l8), .equal(e8), .max_out(mx8), .min_out(mn8), .out_valid(ov8));
    comparator #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .in_valid(v16), .signed_mode(s16),
        .greater(g16), .lesser(l16), .equal(e16), .max_out(mx16), .min_out(mn16), .out_valid(ov16));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive on the falling edge, then return 1 time unit after the next rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    function automatic int toValue(input logic [15:0] x, input logic sm);
        int v;
        v = int'(x);
        if (sm && v >= 32768) v = v - 65536;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [0:0] pa [4];
        logic [0:0] pb [4];
        logic [2:0] pf [4];
        logic ref_g, ref_l, ref_e;
        logic [15:0] ref_max, ref_min;
        int va, vb;

        pa[0] = 1'b0; pb[0] = 1'b0; pf[0] = 3'b001;
        pa[1] = 1'b0; pb[1] = 1'b1; pf[1] = 3'b010;
        pa[2] = 1'b1; pb[2] = 1'b0; pf[2] = 3'b100;
        pa[3] = 1'b1; pb[3] = 1'b1; pf[3] = 3'b001;

        // Reset state
        #12;
        checkOutput("reset_flags16", {g16, l16, e16}, 3'b000);
        checkOutput("reset_max16", mx16, 0);
        checkOutput("reset_min16", mn16, 0);
        checkOutput("reset_ov16", ov16, 0);
        checkOutput("reset_flags1", {g1, l1, e1, ov1}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=1 unsigned truth table, back to back
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a1 = pa[k]; b1 = pb[k]; v1 = 1'b1; s1 = 1'b0;
            applyStimulus();
            checkOutput($sformatf("w1_flags_%0d", k), {g1, l1, e1}, pf[k]);
            checkOutput($sformatf("w1_ov_%0d", k), ov1, 1);
        end
        // WIDTH=1 signed: 1 is -1, so 1 < 0
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b1;
        applyStimulus();
        checkOutput("w1_signed_flags", {g1, l1, e1}, 3'b010);
        checkOutput("w1_signed_max", mx1, 0);
        checkOutput("w1_signed_min", mn1, 1);
        @(negedge clk);
        v1 = 1'b0;
        applyStimulus();
        checkOutput("w1_ov_drop", ov1, 0);

        // WIDTH=4 unsigned vs signed
        @(negedge clk);
        a4 = 4'b1000; b4 = 4'b0001; s4 = 1'b0; v4 = 1'b1;
        applyStimulus();
        checkOutput("w4_uns_flags", {g4, l4, e4}, 3'b100);
        checkOutput("w4_uns_max", mx4, 4'b1000);
        checkOutput("w4_uns_min", mn4, 4'b0001);
        @(negedge clk);
        s4 = 1'b1;
        applyStimulus();
        checkOutput("w4_sgn_flags", {g4, l4, e4}, 3'b010);
        checkOutput("w4_sgn_max", mx4, 4'b0001);
        checkOutput("w4_sgn_min", mn4, 4'b1000);
        @(negedge clk);
        v4 = 1'b0;

        // WIDTH=8 equal operands
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h5A; v8 = 1'b1;
        applyStimulus();
        checkOutput("w8_eq_flags", {g8, l8, e8}, 3'b001);
        checkOutput("w8_eq_max", mx8, 8'h5A);
        checkOutput("w8_eq_min", mn8, 8'h5A);

        // Single sample then idle: result holds, out_valid pulses once
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd7;
        applyStimulus();
        checkOutput("w8_hold_lesser_0", l8, 1);
        checkOutput("w8_hold_ov_0", ov8, 1);
        @(negedge clk);
        v8 = 1'b0; a8 = 8'd200; b8 = 8'd1;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus();
            checkOutput($sformatf("w8_hold_lesser_%0d", k), l8, 1);
            checkOutput($sformatf("w8_hold_ov_%0d", k), ov8, 0);
            checkOutput($sformatf("w8_hold_max_%0d", k), mx8, 8'd7);
        end

        // Asynchronous reset between edges while a sample is pending
        @(negedge clk);
        a16 = 16'd100; b16 = 16'd50; s16 = 1'b0; v16 = 1'b1;
        applyStimulus();
        checkOutput("w16_pre_rst_greater", g16, 1);
        @(negedge clk);
        a16 = 16'd7; b16 = 16'd9;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_flags", {g16, l16, e16, ov16}, 4'b0000);
        checkOutput("rst_async_max", mx16, 0);
        checkOutput("rst_async_min", mn16, 0);
        applyStimulus();
        checkOutput("rst_hold_ov", ov16, 0);
        @(negedge clk);
        rst = 1'b0; v16 = 1'b0;
        applyStimulus();
        checkOutput("rst_no_pulse_ov", ov16, 0);
        checkOutput("rst_no_pulse_flags", {g16, l16, e16}, 3'b000);
        @(negedge clk);
        a16 = 16'd20; b16 = 16'd20; v16 = 1'b1;
        applyStimulus();
        checkOutput("post_rst_flags", {g16, l16, e16}, 3'b001);
        checkOutput("post_rst_max", mx16, 16'd20);
        checkOutput("post_rst_ov", ov16, 1);

        // Randomized 16-bit stream against an integer reference model
        ref_g = 1'b0; ref_l = 1'b0; ref_e = 1'b1;
        ref_max = 16'd20; ref_min = 16'd20;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            v16 = ($urandom_range(0, 3) != 0);
            s16 = $urandom_range(0, 1);
            a16 = 16'($urandom);
            b16 = ($urandom_range(0, 9) == 0) ? a16 : 16'($urandom);
            if (v16) begin
                va = toValue(a16, s16);
                vb = toValue(b16, s16);
                ref_g = (va > vb);
                ref_l = (va < vb);
                ref_e = (va == vb);
                ref_max = (va >= vb) ? a16 : b16;
                ref_min = (va >= vb) ? b16 : a16;
            end
            applyStimulus();
            checkOutput($sformatf("rnd_flags_%0d", n), {g16, l16, e16}, {ref_g, ref_l, ref_e});
            checkOutput($sformatf("rnd_max_%0d", n), mx16, ref_max);
            checkOutput($sformatf("rnd_min_%0d", n), mn16, ref_min);
            checkOutput($sformatf("rnd_ov_%0d", n), ov16, v16);
            if (ov16) begin
                checkOutput($sformatf("rnd_onehot_%0d", n), 32'(g16) + 32'(l16) + 32'(e16), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
